// File: rtl/perm_pkg.sv
// rtl/perm_pkg.sv - shared geometry, types and helpers for the Keccak state unload path
package perm_pkg;
    localparam int X_AXIS  = 5;
    localparam int Y_AXIS  = 5;
    localparam int Z_AXIS  = 64;
    localparam int CHUNK_W = 200;
    localparam int NCHUNK  = 8;
    localparam int STATE_W = X_AXIS * Y_AXIS * Z_AXIS;
    localparam int IDX_W   = 3;
    localparam int PAR_W   = 8;
    localparam int PAR_GRP = CHUNK_W / PAR_W;

    typedef logic [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0] lane_arr_t;
    typedef logic [STATE_W-1:0]                        state_lin_t;
    typedef logic [CHUNK_W-1:0]                        chunk_t;

    typedef enum logic {IDLE, SEND} unload_st_t;

    // Linear bit position of lane bit (x,y,z): lanes are laid out row by row in y.
    function automatic int lin_idx(input int x, input int y, input int z);
        return Z_AXIS * (X_AXIS * y + x) + z;
    endfunction

    // Even parity over each 25-bit group of a chunk.
    function automatic logic [PAR_W-1:0] chunk_par(input chunk_t c);
        logic [PAR_W-1:0] p;
        for (int j = 0; j < PAR_W; j++) begin
            p[j] = ^c[j*PAR_GRP +: PAR_GRP];
        end
        return p;
    endfunction
endpackage

// File: rtl/perm_unload_if.sv
// rtl/perm_unload_if.sv - chunked output beat bus (pushout/stopin/doutix/dout[/dout_par])
// master: drives pushout, doutix, dout (and dout_par when PERM_OUT_PARITY_EN); samples stopin
// slave : samples beats; drives the stopin stall
interface perm_unload_if;
    import perm_pkg::*;

    logic             pushout;
    logic             stopin;
    logic [IDX_W-1:0] doutix;
    chunk_t           dout;
`ifdef PERM_OUT_PARITY_EN
    logic [PAR_W-1:0] dout_par;

    modport master (output pushout, doutix, dout, dout_par, input stopin);
    modport slave  (input pushout, doutix, dout, dout_par, output stopin);
`else
    modport master (output pushout, doutix, dout, input stopin);
    modport slave  (input pushout, doutix, dout, output stopin);
`endif
endinterface

// File: rtl/perm_flatten.sv
// rtl/perm_flatten.sv - combinational [x][y][z] lane array to linear state vector
// lanes in : packed lane_arr_t
// lin   out: bit lin_idx(x,y,z) = lanes[x][y][z]
module perm_flatten
    import perm_pkg::*;
(
    input  lane_arr_t  lanes,
    output state_lin_t lin
);
    for (genvar gx = 0; gx < X_AXIS; gx++) begin : g_x
        for (genvar gy = 0; gy < Y_AXIS; gy++) begin : g_y
            // Whole lanes stay contiguous, so each lane moves as one 64-bit slice.
            assign lin[lin_idx(gx, gy, 0) +: Z_AXIS] = lanes[gx][gy];
        end
    end
endmodule

// File: rtl/perm_unload.sv
// rtl/perm_unload.sv - send one Keccak state as 8 ordered 200-bit beats
// clk, reset (async, active-high); loadin/state_in/load_rdy: state capture handshake;
// busy: high while sending; out_if (master): pushout/doutix/dout beats, stopin stall.
// Optional: PERM_OUT_PARITY_EN adds registered per-25-bit even parity dout_par.
module perm_unload
    import perm_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               loadin,
    input  lane_arr_t          state_in,
    output logic               load_rdy,
    output logic               busy,
    perm_unload_if.master      out_if
);
    unload_st_t       st_q, st_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    state_lin_t       state_q;
    state_lin_t       flat;
    logic             capture;
    logic             launch;
    chunk_t           chunk_sel;

    perm_flatten u_flatten (
        .lanes (state_in),
        .lin   (flat)
    );

    assign chunk_sel = state_q[idx_q * CHUNK_W +: CHUNK_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q <= IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d     = st_q;
        idx_d    = idx_q;
        capture  = 1'b0;
        launch   = 1'b0;
        load_rdy = 1'b0;
        busy     = 1'b0;
        case (st_q)
            IDLE: begin
                load_rdy = 1'b1;
                if (loadin) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    st_d    = SEND;
                end
            end
            SEND: begin
                busy = 1'b1;
                if (!out_if.stopin) begin
                    launch = 1'b1;
                    // Last beat wraps idx to 0 naturally as the FSM returns to IDLE.
                    idx_d  = idx_q + 1'b1;
                    if (idx_q == IDX_W'(NCHUNK - 1)) begin
                        st_d = IDLE;
                    end
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q          <= '0;
            state_q        <= '0;
            out_if.pushout <= 1'b0;
            out_if.doutix  <= '0;
            out_if.dout    <= '0;
`ifdef PERM_OUT_PARITY_EN
            out_if.dout_par <= '0;
`endif
        end else begin
            idx_q          <= idx_d;
            out_if.pushout <= launch;
            if (capture) begin
                state_q <= flat;
            end
            // Beat data holds through stalls so the receiver sees a stable bus.
            if (launch) begin
                out_if.dout   <= chunk_sel;
                out_if.doutix <= idx_q;
`ifdef PERM_OUT_PARITY_EN
                out_if.dout_par <= chunk_par(chunk_sel);
`endif
            end
        end
    end
endmodule

// File: tb/tb_perm_unload.sv
// tb/tb_perm_unload.sv - self-checking bench for perm_unload (PERM_OUT_PARITY_EN optional)
module tb_perm_unload;
    import perm_pkg::*;

    logic      clk = 1'b0;
    logic      reset = 1'b1;
    logic      loadin = 1'b0;
    lane_arr_t state_in = '0;
    logic      load_rdy;
    logic      busy;

    perm_unload_if bus ();

    perm_unload dut (
        .clk      (clk),
        .reset    (reset),
        .loadin   (loadin),
        .state_in (state_in),
        .load_rdy (load_rdy),
        .busy     (busy),
        .out_if   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int x;
        int y;
        int z;
        int beat;
        int bitpos;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: bit (x,y,z) lands at 64*(5y+x)+z of the 1600-bit stream.
    function automatic logic [1599:0] model_lin(input lane_arr_t s);
        logic [1599:0] l;
        l = '0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                for (int z = 0; z < 64; z++)
                    l[64 * (5 * y + x) + z] = s[x][y][z];
        return l;
    endfunction

    function automatic lane_arr_t rand_state();
        lane_arr_t s;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                s[x][y] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic load_state(input lane_arr_t s);
        int w;
        w = 0;
        while (!load_rdy && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk("load_rdy_wait", load_rdy, 1'b1);
        state_in = s;
        loadin   = 1'b1;
        @(posedge clk); #1;
        loadin = 1'b0;
        chk("busy_after_load", busy, 1'b1);
        chk("no_beat_at_capture", bus.pushout, 1'b0);
    endtask

    // mode 0: no stall, 1: random stall, 2: two stall cycles right after beat 2
    task automatic recv_frame(input logic [1599:0] exp_lin, input int mode, input string tag);
        int   got, cyc, stall_left;
        logic s;
        logic [199:0] exp_chunk;
        got = 0; cyc = 0; stall_left = 0;
        while (got < 8 && cyc < 200) begin
            if (mode == 1) s = ($urandom_range(0, 2) == 0);
            else if (mode == 2) s = (stall_left > 0);
            else s = 1'b0;
            if (mode == 2 && stall_left > 0) stall_left--;
            bus.stopin = s;
            @(posedge clk); #1;
            cyc++;
            if (s) begin
                chk({tag, "_stall_pushout"}, bus.pushout, 1'b0);
                if (got > 0) chk({tag, "_stall_hold_ix"}, bus.doutix, 200'(got - 1));
            end else begin
                chk({tag, "_pushout"}, bus.pushout, 1'b1);
                exp_chunk = exp_lin[200 * got +: 200];
                chk({tag, "_doutix"}, bus.doutix, 200'(got));
                chk({tag, "_dout"}, bus.dout, exp_chunk);
`ifdef PERM_OUT_PARITY_EN
                begin
                    logic [7:0] p;
                    for (int j = 0; j < 8; j++) p[j] = ^exp_chunk[25 * j +: 25];
                    chk({tag, "_dout_par"}, bus.dout_par, p);
                end
`endif
                if (mode == 2 && got == 2) stall_left = 2;
                got++;
            end
        end
        bus.stopin = 1'b0;
        chk({tag, "_beats_received"}, 200'(got), 200'd8);
        chk({tag, "_load_rdy_after_last"}, load_rdy, 1'b1);
        chk({tag, "_busy_after_last"}, busy, 1'b0);
    endtask

    initial begin
        lane_arr_t     s, s2;
        logic [1599:0] e;

        bus.stopin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pushout", bus.pushout, 1'b0);
        chk("rst_doutix", bus.doutix, '0);
        chk("rst_dout", bus.dout, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_load_rdy", load_rdy, 1'b1);
`ifdef PERM_OUT_PARITY_EN
        chk("rst_dout_par", bus.dout_par, '0);
`endif
        reset = 1'b0;
        @(posedge clk); #1;

        // Single-bit placement table: {x, y, z} -> {beat, bit within beat}
        vecs[0] = '{0, 0, 0,  0, 0};
        vecs[1] = '{4, 4, 63, 7, 199};
        vecs[2] = '{3, 0, 0,  0, 192};
        vecs[3] = '{0, 3, 0,  4, 160};
        for (int i = 0; i < 4; i++) begin
            s = '0;
            s[vecs[i].x][vecs[i].y][vecs[i].z] = 1'b1;
            e = '0;
            e[200 * vecs[i].beat + vecs[i].bitpos] = 1'b1;
            load_state(s);
            recv_frame(e, 0, $sformatf("vec%0d", i));
        end

        // All-ones state: every beat all ones, parity 8'hFF
        s = '1;
        load_state(s);
        recv_frame('1, 0, "ones");

        // Stall for two cycles after beat 2
        s = rand_state();
        load_state(s);
        recv_frame(model_lin(s), 2, "stall2");

        // Random states with random stalls
        for (int i = 0; i < 6; i++) begin
            s = rand_state();
            load_state(s);
            recv_frame(model_lin(s), 1, $sformatf("rnd%0d", i));
        end

        // loadin held with a different state while busy
        s  = rand_state();
        s2 = rand_state();
        load_state(s);
        state_in = s2;
        loadin   = 1'b1;
        recv_frame(model_lin(s), 0, "busy_frameA");
        @(posedge clk); #1;
        loadin = 1'b0;
        chk("busy_B_captured", busy, 1'b1);
        chk("busy_B_no_beat", bus.pushout, 1'b0);
        recv_frame(model_lin(s2), 0, "busy_frameB");

        // Reset after beat 3
        s = rand_state();
        e = model_lin(s);
        load_state(s);
        bus.stopin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("rstmid_pushout", bus.pushout, 1'b1);
            chk("rstmid_doutix", bus.doutix, 200'(i));
        end
        reset = 1'b1;
        #1;
        chk("rstmid_abort_pushout", bus.pushout, 1'b0);
        chk("rstmid_abort_busy", busy, 1'b0);
        chk("rstmid_abort_load_rdy", load_rdy, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rstmid_quiet_pushout", bus.pushout, 1'b0);
            chk("rstmid_quiet_load_rdy", load_rdy, 1'b1);
        end
        s = rand_state();
        load_state(s);
        recv_frame(model_lin(s), 0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
